// File: rtl/pong_match_sequencer.sv
// Pong match controller: game-phase FSM, point scores and ball datapath gating.
// Every output is registered and computed from the next state, so an input
// sampled at one edge is reflected on the outputs right after that edge.
module pong_match_sequencer #(
  parameter int unsigned MAX_SCORE   = 11,
  parameter int unsigned SAFE_START  = 2_500_000,
  parameter int unsigned SERVE_DELAY = 50_352_112,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       pause_req,
  output logic       spawn_ball,
  output logic       serve_dir,
  output logic       sq_shown,
  output logic       ball_run,
  output logic       game_startup,
  output logic       game_over,
  output logic       paused,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2
);

  localparam int unsigned SCORE_W = 4;

  localparam logic [2:0] ST_STARTUP = 3'd0;
  localparam logic [2:0] ST_SERVE   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_PAUSE   = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  localparam logic [CNT_W-1:0]   SAFE_CNT   = CNT_W'(SAFE_START);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] MAX_PTS    = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] PTS_ONE    = SCORE_W'(1);

  logic [2:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               armed, armed_nxt;
  logic [SCORE_W-1:0] p1_nxt, p2_nxt, pts;
  logic               dir_nxt, spawn_nxt;
  logic               shown_nxt, run_nxt, startup_nxt, over_nxt, paused_nxt;

  // State, delay counter, scores and registered outputs.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state        <= ST_STARTUP;
      cnt          <= '0;
      armed        <= 1'b0;
      score_p1     <= '0;
      score_p2     <= '0;
      serve_dir    <= 1'b0;
      spawn_ball   <= 1'b0;
      sq_shown     <= 1'b0;
      ball_run     <= 1'b0;
      game_startup <= 1'b1;
      game_over    <= 1'b0;
      paused       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      armed        <= armed_nxt;
      score_p1     <= p1_nxt;
      score_p2     <= p2_nxt;
      serve_dir    <= dir_nxt;
      spawn_ball   <= spawn_nxt;
      sq_shown     <= shown_nxt;
      ball_run     <= run_nxt;
      game_startup <= startup_nxt;
      game_over    <= over_nxt;
      paused       <= paused_nxt;
    end
  end

  // Next-state, scoring and output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed;
    p1_nxt    = score_p1;
    p2_nxt    = score_p2;
    dir_nxt   = serve_dir;
    spawn_nxt = 1'b0;
    pts       = '0;

    case (state)
      ST_STARTUP: begin
        // Buttons are ignored until the power-on guard has elapsed.
        if (cnt < SAFE_CNT) begin
          cnt_nxt = cnt + CNT_ONE;
        end else if (|btn) begin
          state_nxt = ST_SERVE;
          p1_nxt    = '0;
          p2_nxt    = '0;
          spawn_nxt = 1'b1;
          dir_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end

      ST_SERVE: begin
        if (cnt == SERVE_LAST) begin
          state_nxt = ST_PLAY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_PLAY: begin
        if (miss_right || miss_left) begin
          // A right-wall miss wins when both walls report in the same cycle.
          if (miss_right) begin
            pts     = (score_p1 >= MAX_PTS) ? score_p1 : score_p1 + PTS_ONE;
            p1_nxt  = pts;
            dir_nxt = 1'b1;
          end else begin
            pts     = (score_p2 >= MAX_PTS) ? score_p2 : score_p2 + PTS_ONE;
            p2_nxt  = pts;
            dir_nxt = 1'b0;
          end
          if (pts >= MAX_PTS) begin
            state_nxt = ST_OVER;
            armed_nxt = 1'b0;
          end else begin
            state_nxt = ST_SERVE;
            spawn_nxt = 1'b1;
            cnt_nxt   = '0;
          end
        end else if (pause_req) begin
          state_nxt = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (pause_req) begin
          state_nxt = ST_PLAY;
        end
      end

      ST_OVER: begin
        // A button still held from the final rally must be released first.
        if (!armed) begin
          if (btn == 4'b0000) begin
            armed_nxt = 1'b1;
          end
        end else if (|btn) begin
          state_nxt = ST_SERVE;
          armed_nxt = 1'b0;
          p1_nxt    = '0;
          p2_nxt    = '0;
          spawn_nxt = 1'b1;
          dir_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_STARTUP;
        cnt_nxt   = '0;
        armed_nxt = 1'b0;
      end
    endcase

    startup_nxt = (state_nxt == ST_STARTUP);
    over_nxt    = (state_nxt == ST_OVER);
    paused_nxt  = (state_nxt == ST_PAUSE);
    run_nxt     = (state_nxt == ST_PLAY);
    shown_nxt   = (state_nxt == ST_PLAY) || (state_nxt == ST_PAUSE);
  end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Bench for pong_match_sequencer: directed stimulus pushes hand-computed
// expectations into queues; a negedge monitor pops and compares them.
module tb_pong_match_sequencer;

  logic       clk_0;
  logic       rst;
  logic [3:0] btn;
  logic       miss_left, miss_right, pause_req;
  logic       spawn_ball, serve_dir, sq_shown, ball_run;
  logic       game_startup, game_over, paused;
  logic [3:0] score_p1, score_p2;

  pong_match_sequencer #(
    .MAX_SCORE  (3),
    .SAFE_START (10),
    .SERVE_DELAY(20),
    .CNT_W      (8)
  ) dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .btn         (btn),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .pause_req   (pause_req),
    .spawn_ball  (spawn_ball),
    .serve_dir   (serve_dir),
    .sq_shown    (sq_shown),
    .ball_run    (ball_run),
    .game_startup(game_startup),
    .game_over   (game_over),
    .paused      (paused),
    .score_p1    (score_p1),
    .score_p2    (score_p2)
  );

  typedef struct {
    int          cyc;
    logic [14:0] v;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  spawn_q[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          done = 0;
  bit          fin = 0;
  logic        spawn_prev = 1'b0;
  logic [14:0] act;

  assign act = {spawn_ball, serve_dir, sq_shown, ball_run, game_startup,
                game_over, paused, score_p1, score_p2};

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  always @(posedge clk_0) cyc <= cyc + 1;

  function automatic logic [14:0] vec(input logic sp, input logic dir,
                                      input logic shown, input logic run,
                                      input logic st, input logic ov,
                                      input logic pa, input logic [3:0] s1,
                                      input logic [3:0] s2);
    return {sp, dir, shown, run, st, ov, pa, s1, s2};
  endfunction

  task automatic expect_at(input int c, input logic [14:0] v, input string name);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Spawn pulse at cycle s, ball hidden, then shown SERVE_DELAY (20) cycles later.
  task automatic serve_seq(input int s, input logic dir, input logic [3:0] s1,
                           input logic [3:0] s2, input bit full);
    expect_at(s,     vec(1'b1, dir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s1, s2), "spawn");
    expect_at(s + 1, vec(1'b0, dir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s1, s2), "serve_hidden");
    spawn_q.push_back({dir, s1, s2});
    if (full) begin
      expect_at(s + 19, vec(1'b0, dir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s1, s2), "serve_last");
      expect_at(s + 20, vec(1'b0, dir, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, s1, s2), "play_start");
    end
  endtask

  task automatic tick();
    @(posedge clk_0);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: timed output snapshots plus every spawn pulse against the spawn queue.
  always @(negedge clk_0) begin
    if (!fin) begin
      for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          n_tests++;
          if (act !== exp_q[i].v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", exp_q[i].name, cyc, act, exp_q[i].v);
          end
          exp_q.delete(i);
        end else if (exp_q[i].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s cyc=%0d not checked at cyc=%0d", exp_q[i].name, cyc, exp_q[i].cyc);
          exp_q.delete(i);
        end
      end
      if (spawn_ball === 1'b1) begin
        n_tests++;
        if (spawn_q.size() == 0) begin
          n_fail++;
          $display("FAIL spawn_unexpected cyc=%0d got=1 want=0", cyc);
        end else begin
          logic [8:0] e;
          e = spawn_q.pop_front();
          if ({serve_dir, score_p1, score_p2} !== e) begin
            n_fail++;
            $display("FAIL spawn_payload cyc=%0d got=%b want=%b", cyc,
                     {serve_dir, score_p1, score_p2}, e);
          end
        end
        if (spawn_prev === 1'b1) begin
          n_fail++;
          $display("FAIL spawn_double cyc=%0d got=2 cycles want=1", cyc);
        end
      end
      spawn_prev = spawn_ball;
      if (done) begin
        n_tests++;
        if (exp_q.size() != 0 || spawn_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover got=%0d/%0d pending want=0/0", exp_q.size(), spawn_q.size());
        end
        fin = 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] rst_v, start_v, over_v, pause_v, play_v;
    int c0, t, u, s, r;
    rst_v   = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    start_v = rst_v;
    rst = 1'b0; btn = 4'b0000;
    miss_left = 1'b0; miss_right = 1'b0; pause_req = 1'b0;

    // Reset values, then release with a button held from the start.
    repeat (3) tick();
    expect_at(cyc, rst_v, "reset_vals");
    tick();
    rst = 1'b1;
    btn = 4'b0001;
    c0  = cyc;
    expect_at(c0 + 5,  start_v, "startup_guard");
    expect_at(c0 + 10, start_v, "startup_last_guard");
    serve_seq(c0 + 11, 1'b0, 4'd0, 4'd0, 1'b1);
    wait_until(c0 + 31);
    btn = 4'b0000;

    // Right-wall miss: P1 scores, serve to the right.
    t = cyc;
    miss_right = 1'b1;
    serve_seq(t + 1, 1'b1, 4'd1, 4'd0, 1'b1);
    tick();
    miss_right = 1'b0;
    wait_until(t + 21);

    // Both walls in one cycle: only the right miss counts.
    t = cyc;
    miss_left = 1'b1; miss_right = 1'b1;
    serve_seq(t + 1, 1'b1, 4'd2, 4'd0, 1'b1);
    tick();
    miss_left = 1'b0; miss_right = 1'b0;
    wait_until(t + 21);

    // Pause, ignored miss while paused, resume.
    pause_v = vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0);
    play_v  = vec(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    t = cyc;
    pause_req = 1'b1;
    expect_at(t + 1, pause_v, "pause_enter");
    tick();
    pause_req = 1'b0;
    miss_left = 1'b1;
    expect_at(t + 2, pause_v, "pause_miss_ignored");
    tick();
    miss_left = 1'b0;
    expect_at(t + 3, pause_v, "pause_hold");
    tick();
    pause_req = 1'b1;
    expect_at(t + 4, play_v, "pause_resume");
    tick();
    pause_req = 1'b0;
    expect_at(t + 5, play_v, "play_hold");
    tick();

    // Two left misses keep serving; the third ends the match.
    for (int k = 1; k <= 2; k++) begin
      t = cyc;
      miss_left = 1'b1;
      serve_seq(t + 1, 1'b0, 4'd2, 4'(k), 1'b1);
      tick();
      miss_left = 1'b0;
      wait_until(t + 21);
    end
    btn = 4'b0010;
    tick();
    over_v = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3);
    t = cyc;
    miss_left = 1'b1;
    expect_at(t + 1, over_v, "over_enter");
    tick();
    miss_left = 1'b0;
    expect_at(t + 6, over_v, "over_btn_held");
    wait_until(t + 6);

    // Release arms the exit; the next press restarts the match.
    btn = 4'b0000;
    u = cyc;
    expect_at(u + 1, over_v, "over_armed");
    tick();
    btn = 4'b1000;
    s = u + 2;
    serve_seq(s, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    btn = 4'b0000;

    // Reset mid-serve at cnt=7 must clear outputs before the next edge.
    wait_until(s + 7);
    rst = 1'b0;
    expect_at(cyc, rst_v, "reset_mid_serve");
    tick();
    expect_at(cyc, rst_v, "reset_hold");
    tick();
    rst = 1'b1;
    r = cyc;
    expect_at(r + 1, start_v, "startup_after_rst");
    expect_at(r + 3, start_v, "startup_after_rst_hold");
    wait_until(r + 4);

    done = 1;
    wait (fin);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
